demux_deser2: RTL

DEMUX_DESER2 -- requirements
Module: demux_deser2

---
 rtl/demux_deser2.sv | 139 +++++++++++++
 1 files changed

// File: rtl/demux_deser2.sv
// Two-channel MSB-first deserializer fed by a 1:2 bit demux; one holding register with valid/ready per channel.
// Define DESER_PARITY_EN to append a trailing even-parity bit to each frame (bad-parity words are discarded).
module demux_deser2 #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             bit_vld,
  input  logic             S,
  input  logic             Y0,
  input  logic             Y1,
  output logic [WIDTH-1:0] ch0_data,
  output logic             ch0_valid,
  input  logic             ch0_ready,
  output logic [WIDTH-1:0] ch1_data,
  output logic             ch1_valid,
  input  logic             ch1_ready,
  output logic [1:0]       overflow,
  output logic [1:0]       par_err,
  input  logic             err_clr
);

`ifdef DESER_PARITY_EN
  localparam int FRAME = WIDTH + 1;
`else
  localparam int FRAME = WIDTH;
`endif
  localparam int CW = $clog2(FRAME);

  typedef enum logic {IDLE, SHIFT} sst_t;
  typedef enum logic {EMPTY, FULL} ost_t;

  sst_t             sst_q  [2];
  sst_t             sst_d  [2];
  ost_t             ost_q  [2];
  ost_t             ost_d  [2];
  logic [CW-1:0]    cnt_q  [2];
  logic [CW-1:0]    cnt_d  [2];
  logic [WIDTH-1:0] sh_q   [2];
  logic [WIDTH-1:0] sh_d   [2];
  logic [WIDTH-1:0] hold_q [2];
  logic [WIDTH-1:0] hold_d [2];
  logic [WIDTH-1:0] word   [2];
  logic [1:0]       ovf_q, ovf_d;
  logic [1:0]       acc, last, done, xfer, bits, rdy;

  assign acc  = {bit_vld & S, bit_vld & ~S};
  assign bits = {Y1, Y0};
  assign rdy  = {ch1_ready, ch0_ready};

`ifdef DESER_PARITY_EN
  logic [1:0] perr_q, perr_d;
`endif

  always_comb begin
    ovf_d = err_clr ? 2'b00 : ovf_q;
`ifdef DESER_PARITY_EN
    perr_d = err_clr ? 2'b00 : perr_q;
`endif
    for (int i = 0; i < 2; i++) begin
      sst_d[i]  = sst_q[i];
      ost_d[i]  = ost_q[i];
      cnt_d[i]  = cnt_q[i];
      sh_d[i]   = sh_q[i];
      hold_d[i] = hold_q[i];
      last[i]   = acc[i] && (cnt_q[i] == CW'(FRAME - 1));
`ifdef DESER_PARITY_EN
      // Data is already complete in the shift register when the parity bit arrives.
      word[i] = sh_q[i];
      done[i] = last[i] && !(^{sh_q[i], bits[i]});
      if (last[i] && (^{sh_q[i], bits[i]}))
        perr_d[i] = 1'b1;
`else
      word[i] = {sh_q[i][WIDTH-2:0], bits[i]};
      done[i] = last[i];
`endif

      if (acc[i]) begin
`ifdef DESER_PARITY_EN
        if (!last[i])
          sh_d[i] = {sh_q[i][WIDTH-2:0], bits[i]};
`else
        sh_d[i] = {sh_q[i][WIDTH-2:0], bits[i]};
`endif
        cnt_d[i] = last[i] ? '0 : cnt_q[i] + CW'(1);
        sst_d[i] = last[i] ? IDLE : SHIFT;
      end

      xfer[i] = (ost_q[i] == FULL) && rdy[i];
      if (done[i] && ((ost_q[i] == EMPTY) || xfer[i])) begin
        ost_d[i]  = FULL;
        hold_d[i] = word[i];
      end else if (xfer[i]) begin
        ost_d[i] = EMPTY;
      end
      if (done[i] && (ost_q[i] == FULL) && !rdy[i])
        ovf_d[i] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        sst_q[i]  <= IDLE;
        ost_q[i]  <= EMPTY;
        cnt_q[i]  <= '0;
        sh_q[i]   <= '0;
        hold_q[i] <= '0;
      end
      ovf_q <= 2'b00;
    end else begin
      for (int i = 0; i < 2; i++) begin
        sst_q[i]  <= sst_d[i];
        ost_q[i]  <= ost_d[i];
        cnt_q[i]  <= cnt_d[i];
        sh_q[i]   <= sh_d[i];
        hold_q[i] <= hold_d[i];
      end
      ovf_q <= ovf_d;
    end
  end

`ifdef DESER_PARITY_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) perr_q <= 2'b00;
    else        perr_q <= perr_d;
  end
  assign par_err = perr_q;
`else
  assign par_err = 2'b00;
`endif

  assign ch0_data  = hold_q[0];
  assign ch1_data  = hold_q[1];
  assign ch0_valid = (ost_q[0] == FULL);
  assign ch1_valid = (ost_q[1] == FULL);
  assign overflow  = ovf_q;

endmodule
